// File: rtl/hsst_frame_rx.sv
// hsst_frame_rx: HSST lane-3 receive frame delineator.
// Locks onto the idle comma stream, cuts fixed-length data frames out of it,
// and emits a registered word stream with SOF/EOF/abort marks. Good-frame and
// error-event statistics are kept alongside.
module hsst_frame_rx #(
    parameter int unsigned FRAME_WORDS = 128,
    parameter logic [31:0] IDLE_WORD   = 32'hFF0000BC,
    parameter logic [3:0]  IDLE_K      = 4'b0001,
    parameter int unsigned LOCK_IDLES  = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             rx3_clk,
    input  logic             rx3_rst,
    input  logic             lane_ready,
    input  logic [31:0]      hsst_rxd3,
    input  logic [3:0]       hsst_rxk3,
    input  logic [3:0]       hsst_rx_err3,
    output logic             out_valid,
    output logic [31:0]      out_data,
    output logic             out_sof,
    output logic             out_eof,
    output logic             out_abort,
    output logic             locked,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned WCNT_W = $clog2(FRAME_WORDS + 1);

    typedef enum logic [1:0] {
        ST_UNLOCK = 2'd0,
        ST_WAIT   = 2'd1,
        ST_FRAME  = 2'd2,
        ST_DROP   = 2'd3
    } state_t;

    state_t            state_q;
    logic [3:0]        idle_run_q;
    logic [WCNT_W-1:0] wcnt_q;

    logic word_idle_s;
    logic word_data_s;
    logic word_bad_s;

    // Error counter step that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_W'(1);
        end
    endfunction

    // Any 8b10b error marks the word BAD, even if it otherwise looks like idle or data.
    assign word_idle_s = (hsst_rx_err3 == 4'b0000) && (hsst_rxk3 == IDLE_K) && (hsst_rxd3 == IDLE_WORD);
    assign word_data_s = (hsst_rx_err3 == 4'b0000) && (hsst_rxk3 == 4'b0000);
    assign word_bad_s  = !word_idle_s && !word_data_s;

    // Lock/frame state machine with all outputs and statistics registered.
    always_ff @(posedge rx3_clk) begin
        if (rx3_rst) begin
            state_q    <= ST_UNLOCK;
            idle_run_q <= 4'd0;
            wcnt_q     <= '0;
            out_valid  <= 1'b0;
            out_data   <= 32'd0;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
            out_abort  <= 1'b0;
            locked     <= 1'b0;
            frame_cnt  <= '0;
            err_cnt    <= '0;
        end else begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_abort <= 1'b0;
            if (!lane_ready) begin
                // Lane loss overrides word class; a frame in flight is aborted.
                if (state_q == ST_FRAME) begin
                    out_abort <= 1'b1;
                    err_cnt   <= sat_inc(err_cnt);
                end
                state_q    <= ST_UNLOCK;
                locked     <= 1'b0;
                idle_run_q <= 4'd0;
                wcnt_q     <= '0;
            end else begin
                case (state_q)
                    ST_UNLOCK: begin
                        if (word_idle_s) begin
                            if (idle_run_q == 4'(LOCK_IDLES - 1)) begin
                                state_q    <= ST_WAIT;
                                locked     <= 1'b1;
                                idle_run_q <= 4'd0;
                            end else begin
                                idle_run_q <= idle_run_q + 4'd1;
                            end
                        end else begin
                            idle_run_q <= 4'd0;
                        end
                    end
                    ST_WAIT: begin
                        if (word_data_s) begin
                            out_valid <= 1'b1;
                            out_sof   <= 1'b1;
                            out_data  <= hsst_rxd3;
                            wcnt_q    <= WCNT_W'(1);
                            state_q   <= ST_FRAME;
                        end else if (word_bad_s) begin
                            err_cnt <= sat_inc(err_cnt);
                            state_q <= ST_DROP;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                    ST_FRAME: begin
                        if (word_data_s) begin
                            out_valid <= 1'b1;
                            out_data  <= hsst_rxd3;
                            if (wcnt_q == WCNT_W'(FRAME_WORDS - 1)) begin
                                out_eof   <= 1'b1;
                                frame_cnt <= frame_cnt + CNT_W'(1);
                                wcnt_q    <= '0;
                                state_q   <= ST_WAIT;
                            end else begin
                                wcnt_q <= wcnt_q + WCNT_W'(1);
                            end
                        end else begin
                            // Short frame (idle) or corrupted word: discard the frame.
                            out_abort <= 1'b1;
                            err_cnt   <= sat_inc(err_cnt);
                            wcnt_q    <= '0;
                            state_q   <= word_idle_s ? ST_WAIT : ST_DROP;
                        end
                    end
                    ST_DROP: begin
                        if (word_idle_s) begin
                            state_q <= ST_WAIT;
                        end else begin
                            state_q <= ST_DROP;
                        end
                    end
                    default: begin
                        state_q    <= ST_UNLOCK;
                        locked     <= 1'b0;
                        idle_run_q <= 4'd0;
                        wcnt_q     <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hsst_frame_rx.sv
// tb_hsst_frame_rx: scoreboard bench for hsst_frame_rx with a transaction-level reference model.
module tb_hsst_frame_rx;

    localparam int          FW    = 128;
    localparam logic [31:0] IDLEW = 32'hFF0000BC;
    localparam logic [3:0]  IDLEK = 4'b0001;
    localparam int          LOCKN = 4;
    localparam int          CW    = 16;

    localparam int M_UNLOCK = 0;
    localparam int M_WAIT   = 1;
    localparam int M_FRAME  = 2;
    localparam int M_DROP   = 3;

    logic          rx3_clk;
    logic          rx3_rst;
    logic          lane_ready;
    logic [31:0]   hsst_rxd3;
    logic [3:0]    hsst_rxk3;
    logic [3:0]    hsst_rx_err3;
    logic          out_valid;
    logic [31:0]   out_data;
    logic          out_sof;
    logic          out_eof;
    logic          out_abort;
    logic          locked;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] err_cnt;

    hsst_frame_rx #(
        .FRAME_WORDS(FW), .IDLE_WORD(IDLEW), .IDLE_K(IDLEK), .LOCK_IDLES(LOCKN), .CNT_W(CW)
    ) dut (
        .rx3_clk(rx3_clk), .rx3_rst(rx3_rst), .lane_ready(lane_ready),
        .hsst_rxd3(hsst_rxd3), .hsst_rxk3(hsst_rxk3), .hsst_rx_err3(hsst_rx_err3),
        .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof),
        .out_abort(out_abort), .locked(locked), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    initial rx3_clk = 1'b0;
    always #5 rx3_clk = ~rx3_clk;

    typedef struct {
        bit            v;
        bit            a;
        bit            lk;
        logic [CW-1:0] fc;
        logic [CW-1:0] ec;
        bit            z;
    } st_t;

    typedef struct {
        logic [31:0] d;
        bit          s;
        bit          e;
    } ev_t;

    st_t st_q[$];
    ev_t ev_q[$];

    int checks   = 0;
    int failures = 0;

    // Reference model: link mode, idle run length, words received in the current frame.
    int            m_mode  = M_UNLOCK;
    int            m_idles = 0;
    int            m_pos   = 0;
    bit            m_lk    = 1'b0;
    logic [CW-1:0] m_fc    = '0;
    logic [CW-1:0] m_ec    = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic err_event();
        if (m_ec != {CW{1'b1}}) m_ec = m_ec + 1'b1;
    endtask

    task automatic model_step(input bit r, input bit l, input logic [31:0] d,
                              input logic [3:0] k, input logic [3:0] e);
        st_t s;
        ev_t v;
        bit  is_idle;
        bit  is_data;
        s.v = 1'b0; s.a = 1'b0; s.z = 1'b0;
        is_idle = (e == 4'd0) && (k == IDLEK) && (d == IDLEW);
        is_data = (e == 4'd0) && (k == 4'd0);
        if (r) begin
            m_mode = M_UNLOCK; m_idles = 0; m_pos = 0; m_lk = 1'b0;
            m_fc = '0; m_ec = '0; s.z = 1'b1;
        end else if (!l) begin
            if (m_mode == M_FRAME) begin
                s.a = 1'b1;
                err_event();
            end
            m_mode = M_UNLOCK; m_lk = 1'b0; m_idles = 0; m_pos = 0;
        end else if (m_mode == M_UNLOCK) begin
            m_idles = is_idle ? m_idles + 1 : 0;
            if (m_idles == LOCKN) begin
                m_mode = M_WAIT; m_lk = 1'b1; m_idles = 0;
            end
        end else if (m_mode == M_DROP) begin
            if (is_idle) m_mode = M_WAIT;
        end else if (is_data) begin
            // A data word in WAIT opens a frame; in FRAME it extends it.
            m_pos = m_pos + 1;
            s.v = 1'b1;
            v.d = d; v.s = (m_pos == 1); v.e = (m_pos == FW);
            ev_q.push_back(v);
            if (m_pos == FW) begin
                m_fc = m_fc + 1'b1; m_pos = 0; m_mode = M_WAIT;
            end else begin
                m_mode = M_FRAME;
            end
        end else if (m_mode == M_FRAME) begin
            s.a = 1'b1;
            err_event();
            m_pos = 0;
            m_mode = is_idle ? M_WAIT : M_DROP;
        end else if (!is_idle) begin
            err_event();
            m_mode = M_DROP;
        end
        s.lk = m_lk; s.fc = m_fc; s.ec = m_ec;
        st_q.push_back(s);
    endtask

    task automatic drive(input bit r, input bit l, input logic [31:0] d,
                         input logic [3:0] k, input logic [3:0] e);
        @(negedge rx3_clk);
        rx3_rst = r; lane_ready = l; hsst_rxd3 = d; hsst_rxk3 = k; hsst_rx_err3 = e;
        model_step(r, l, d, k, e);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, $urandom, 4'($urandom), 4'd0);
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, IDLEW, IDLEK, 4'd0);
    endtask

    // Data burst of n words; word bad_at (if >= 0) carries error flags instead.
    task automatic frame(input int n, input bit counting, input int bad_at, input logic [3:0] bad_err);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = counting ? 32'(i) : $urandom;
            if (i == bad_at) drive(1'b0, 1'b1, w, 4'd0, bad_err);
            else             drive(1'b0, 1'b1, w, 4'd0, 4'd0);
        end
    endtask

    task automatic bad_word();
        case ($urandom_range(0, 3))
            0:       drive(1'b0, 1'b1, $urandom, 4'b1111, 4'd0);
            1:       drive(1'b0, 1'b1, IDLEW, IDLEK, 4'b0010);
            2:       drive(1'b0, 1'b1, $urandom, 4'd0, 4'b1000);
            default: drive(1'b0, 1'b1, 32'h12345678, IDLEK, 4'd0);
        endcase
    endtask

    // Monitor: one status entry per driven cycle, one event entry per valid word.
    initial begin
        st_t s;
        ev_t v;
        forever begin
            @(posedge rx3_clk);
            #1;
            if (st_q.size() > 0) begin
                s = st_q.pop_front();
                chk("out_valid", 32'(out_valid), 32'(s.v));
                chk("out_abort", 32'(out_abort), 32'(s.a));
                chk("locked", 32'(locked), 32'(s.lk));
                chk("frame_cnt", 32'(frame_cnt), 32'(s.fc));
                chk("err_cnt", 32'(err_cnt), 32'(s.ec));
                if (s.z) chk("reset_data", out_data, 32'd0);
                if (out_valid === 1'b1) begin
                    if (ev_q.size() == 0) begin
                        chk("unexpected_word", out_data, 32'hDEADDEAD);
                    end else begin
                        v = ev_q.pop_front();
                        chk("out_data", out_data, v.d);
                        chk("out_sof", 32'(out_sof), 32'(v.s));
                        chk("out_eof", 32'(out_eof), 32'(v.e));
                    end
                end else begin
                    chk("sof_no_valid", 32'(out_sof), 32'd0);
                    chk("eof_no_valid", 32'(out_eof), 32'd0);
                end
            end
        end
    end

    initial begin
        rx3_rst = 1'b1; lane_ready = 1'b0; hsst_rxd3 = 32'd0; hsst_rxk3 = 4'd0; hsst_rx_err3 = 4'd0;
        do_reset(2);
        // Basic frame with counting payload.
        idles(LOCKN);
        frame(FW, 1'b1, -1, 4'd0);
        idles(3);
        // Too few idles to lock: frame must be ignored.
        do_reset(1);
        idles(LOCKN - 1);
        frame(FW, 1'b1, -1, 4'd0);
        idles(LOCKN + 1);
        // Short frame then a full one.
        frame(60, 1'b0, -1, 4'd0);
        idles(2);
        frame(FW, 1'b0, -1, 4'd0);
        idles(1);
        // Disparity error mid-frame, extra bad words in DROP, recovery.
        frame(20, 1'b0, 10, 4'b0100);
        bad_word();
        bad_word();
        idles(1);
        frame(FW, 1'b0, -1, 4'd0);
        // Back-to-back frames with no idle between.
        frame(FW, 1'b0, -1, 4'd0);
        frame(FW, 1'b0, -1, 4'd0);
        idles(1);
        // Lane drop mid-frame, relock, full frame.
        frame(50, 1'b0, -1, 4'd0);
        drive(1'b0, 1'b0, $urandom, 4'd0, 4'd0);
        idles(LOCKN);
        frame(FW, 1'b0, -1, 4'd0);
        idles(1);
        // Reset mid-frame: silent return to reset values.
        frame(50, 1'b0, -1, 4'd0);
        do_reset(1);
        idles(LOCKN);
        frame(FW, 1'b0, -1, 4'd0);
        // Randomised mix of link events.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 7))
                0:       idles($urandom_range(1, 6));
                1:       frame(FW, 1'b0, -1, 4'd0);
                2:       frame($urandom_range(1, FW - 1), 1'b0, -1, 4'd0);
                3:       bad_word();
                4:       drive(1'b0, 1'b0, $urandom, 4'($urandom), 4'd0);
                5:       frame(FW, 1'b0, $urandom_range(0, FW - 1), 4'($urandom_range(1, 15)));
                6:       if ($urandom_range(0, 3) == 0) do_reset(1); else idles(LOCKN);
                default: frame($urandom_range(FW - 2, FW), 1'b0, -1, 4'd0);
            endcase
        end
        idles(3);
        @(posedge rx3_clk);
        #2;
        chk("status_drain", 32'(st_q.size()), 32'd0);
        chk("event_drain", 32'(ev_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
